matrizpuntos_axi_slave: RTL and testbench
=========================================

Name: matrizpuntos_axi_slave

Overview:
AXI4-Lite responder for the matrizpuntos peripheral: the slave end that the master VIP bench drives.
- Holds four 32-bit software registers.
- Uses them to drive a multiplexed 8x8 dot-matrix display, one row at a time at a programmable scan rate.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width (only 32 supported)
C_S_AXI_ADDR_WIDTH, 4, AXI address width; 4 words decoded by addr[3:2]

Ports:
s00_axi_aclk  in  1  single clock
s00_axi_areset  in  1  synchronous, active-high reset
s00_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address
s00_axi_awprot  in  3  ignored
s00_axi_awvalid  in  1  write address valid
s00_axi_awready  out  1  write address accepted
s00_axi_wdata  in  32  write data
s00_axi_wstrb  in  4  byte strobes
s00_axi_wvalid  in  1  write data valid
s00_axi_wready  out  1  write data accepted
s00_axi_bresp  out  2  write response, always 2'b00
s00_axi_bvalid  out  1  write response valid
s00_axi_bready  in  1  write response ready
s00_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address
s00_axi_arprot  in  3  ignored
s00_axi_arvalid  in  1  read address valid
s00_axi_arready  out  1  read address accepted
s00_axi_rdata  out  32  read data
s00_axi_rresp  out  2  read response, always 2'b00
s00_axi_rvalid  out  1  read data valid
s00_axi_rready  in  1  read data ready
row_sel  out  8  one-hot active row
col_data  out  8  column pattern for active row

Behaviour:
Register map:
- 0x0 PIX_LO: bytes 0-3 = rows 0-3.
- 0x4 PIX_HI: bytes 0-3 = rows 4-7.
- 0x8 DIV: [15:0] prescaler terminal count; upper bits stored but unused.
- 0xC CTRL: bit0 enable, bit1 invert columns; upper bits stored but unused.
- All 32 bits of every register are R/W and read back exactly as written.

Reset:
- On s00_axi_areset at a clock edge, all registers, prescaler and row index go to 0.
- All ready/valid outputs, rdata, row_sel and col_data go to 0; bresp and rresp are 00.
- Reset mid-transaction drops a pending bvalid/rvalid; no response is issued.

Write channel:
- awready and wready pulse high together for exactly one cycle when awvalid && wvalid && !bvalid && !awready.
- AW and W may arrive in either order; the block waits for both.
- At that same edge, the register at awaddr[3:2] is updated byte-wise per wstrb.
- bvalid rises the next cycle and holds until the bready handshake.
- One write outstanding at a time.

Read channel:
- arready pulses for one cycle when arvalid && !rvalid && !arready.
- rdata is captured from araddr[3:2] at that edge; rvalid rises the next cycle.
- rdata stays stable while rvalid=1 && rready=0; rvalid clears on the handshake.
- If a read and a write to the same register are accepted at the same edge, the read returns the old value.

Scanner:
- When CTRL[0]=1, the prescaler increments each cycle. When it equals DIV[15:0], it clears and the row index advances mod 8 (wraps 7->0).
- DIV=0 advances the row every cycle; each row is held DIV+1 cycles.
- Outputs are registered, one cycle after the row index:
  - row_sel = 1<<row.
  - col_data = selected byte, XOR 8'hFF if CTRL[1].
- When CTRL[0]=0, prescaler and row index are held at 0, and row_sel=col_data=0 (invert not applied).
- Register writes take effect on the next cycle's output.

Test Plan:
1. Write 0x1,0x2,0x3,0x4 to 0x0/0x4/0x8/0xC with wstrb=F, then read back all four -> rdata 1,2,3,4, bresp=rresp=00.
2. PIX_LO=0x00000001, then write 0xAABBCCDD with wstrb=4'b0010 -> read returns 0x0000CC01.
3. awvalid asserted 3 cycles before wvalid, bready held low 5 cycles -> awready/wready pulse in the same single cycle after wvalid rises; bvalid held high 5 cycles, drops the cycle after bready.
4. PIX_LO=0x04030201, PIX_HI=0x08070605, DIV=1, CTRL=1 -> row_sel 01,02,04,...,80, each held 2 cycles, with col_data 01..08; then wraps to row_sel=01, col_data=01.
5. CTRL=3 -> row 0 shows col_data=FE; write CTRL=0 mid-scan -> row_sel=col_data=00 next cycle; re-enable -> restarts at row_sel=01.
6. Assert s00_axi_areset while bvalid=1 -> bvalid=0 next cycle; subsequent reads of all registers return 0.

Source files
------------

// File: rtl/matrizpuntos_axi_slave.sv
// AXI4-Lite slave for the matrizpuntos peripheral: four R/W registers
// feeding a row-multiplexed 8x8 dot-matrix scanner.
module matrizpuntos_axi_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [(C_S_AXI_DATA_WIDTH/8)-1:0] s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    output logic [7:0]                        row_sel,
    output logic [7:0]                        col_data
);

    localparam int NBYTES = C_S_AXI_DATA_WIDTH / 8;

    logic [C_S_AXI_DATA_WIDTH-1:0] regs_q [4];
    logic [C_S_AXI_DATA_WIDTH-1:0] regs_d [4];

    logic                          awready_q, awready_d;
    logic                          bvalid_q,  bvalid_d;
    logic                          arready_q, arready_d;
    logic                          rvalid_q,  rvalid_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q,   rdata_d;

    logic [15:0]                   presc_q,   presc_d;
    logic [2:0]                    row_q,     row_d;
    logic [7:0]                    row_sel_q, row_sel_d;
    logic [7:0]                    col_q,     col_d;

    logic        wr_accept;
    logic        rd_accept;
    logic [1:0]  wr_idx;
    logic [1:0]  rd_idx;
    logic        scan_en;
    logic        scan_inv;
    logic [15:0] scan_div;
    logic [63:0] pix;
    logic [7:0]  row_byte;

    logic unused_inputs;
    assign unused_inputs = &{1'b0, s00_axi_awprot, s00_axi_arprot,
                             s00_axi_awaddr, s00_axi_araddr};

    assign wr_idx   = s00_axi_awaddr[3:2];
    assign rd_idx   = s00_axi_araddr[3:2];
    assign scan_en  = regs_q[3][0];
    assign scan_inv = regs_q[3][1];
    assign scan_div = regs_q[2][15:0];
    assign pix      = {regs_q[1], regs_q[0]};
    assign row_byte = pix[{row_q, 3'b000} +: 8];

    // awready doubles as the single-cycle write strobe; blocking on both
    // awready and bvalid keeps exactly one write in flight.
    assign wr_accept = s00_axi_awvalid && s00_axi_wvalid && !bvalid_q && !awready_q;
    assign rd_accept = s00_axi_arvalid && !rvalid_q && !arready_q;

    always_comb begin
        awready_d = wr_accept;
        arready_d = rd_accept;

        bvalid_d = bvalid_q;
        if (awready_q) begin
            bvalid_d = 1'b1;
        end else if (bvalid_q && s00_axi_bready) begin
            bvalid_d = 1'b0;
        end

        for (int i = 0; i < 4; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_accept) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (s00_axi_wstrb[b]) begin
                    regs_d[wr_idx][8*b +: 8] = s00_axi_wdata[8*b +: 8];
                end
            end
        end

        // Capture from the pre-write register value so a colliding read sees old data.
        rdata_d = rdata_q;
        if (rd_accept) begin
            rdata_d = regs_q[rd_idx];
        end

        rvalid_d = rvalid_q;
        if (arready_q) begin
            rvalid_d = 1'b1;
        end else if (rvalid_q && s00_axi_rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_comb begin
        presc_d   = '0;
        row_d     = '0;
        row_sel_d = '0;
        col_d     = '0;
        if (scan_en) begin
            if (presc_q == scan_div) begin
                row_d = row_q + 3'd1;
            end else begin
                presc_d = presc_q + 16'd1;
                row_d   = row_q;
            end
            row_sel_d = 8'b0000_0001 << row_q;
            col_d     = row_byte ^ {8{scan_inv}};
        end
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            presc_q   <= '0;
            row_q     <= '0;
            row_sel_q <= '0;
            col_q     <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= regs_d[i];
            end
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            presc_q   <= presc_d;
            row_q     <= row_d;
            row_sel_q <= row_sel_d;
            col_q     <= col_d;
        end
    end

    assign s00_axi_awready = awready_q;
    assign s00_axi_wready  = awready_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = 2'b00;
    assign s00_axi_arready = arready_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = 2'b00;
    assign row_sel         = row_sel_q;
    assign col_data        = col_q;

endmodule

// File: tb/tb_matrizpuntos_axi_slave.sv
// Self-checking bench for matrizpuntos_axi_slave: table-driven register
// vectors, hand sequences for handshake corners, randomized R/W and scan checks.
module tb_matrizpuntos_axi_slave;

    logic        clk = 1'b0;
    logic        areset;
    logic [3:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [7:0]  row_sel;
    logic [7:0]  col_data;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] regs_m [4];

    always #5 clk = ~clk;

    matrizpuntos_axi_slave #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(4)
    ) dut (
        .s00_axi_aclk   (clk),
        .s00_axi_areset (areset),
        .s00_axi_awaddr (awaddr),
        .s00_axi_awprot (awprot),
        .s00_axi_awvalid(awvalid),
        .s00_axi_awready(awready),
        .s00_axi_wdata  (wdata),
        .s00_axi_wstrb  (wstrb),
        .s00_axi_wvalid (wvalid),
        .s00_axi_wready (wready),
        .s00_axi_bresp  (bresp),
        .s00_axi_bvalid (bvalid),
        .s00_axi_bready (bready),
        .s00_axi_araddr (araddr),
        .s00_axi_arprot (arprot),
        .s00_axi_arvalid(arvalid),
        .s00_axi_arready(arready),
        .s00_axi_rdata  (rdata),
        .s00_axi_rresp  (rresp),
        .s00_axi_rvalid (rvalid),
        .s00_axi_rready (rready),
        .row_sel        (row_sel),
        .col_data       (col_data)
    );

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    task automatic wait_awready(input string name);
        bit got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (awready) got = 1;
        end
        check(name, {31'd0, awready}, 32'd1);
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1; wvalid = 1; bready = 1;
        wait_awready("wr_awready");
        check("wr_wready", {31'd0, wready}, 32'd1);
        tick();
        awvalid = 0; wvalid = 0;
        check("wr_bvalid", {31'd0, bvalid}, 32'd1);
        check("wr_bresp", {30'd0, bresp}, 32'd0);
        tick();
        check("wr_bvalid_clr", {31'd0, bvalid}, 32'd0);
        regs_m[addr[3:2]] = merge(regs_m[addr[3:2]], data, strb);
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
        bit got = 0;
        araddr = addr; arvalid = 1; rready = 1;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (arready) got = 1;
        end
        check("rd_arready", {31'd0, arready}, 32'd1);
        tick();
        arvalid = 0;
        check("rd_rvalid", {31'd0, rvalid}, 32'd1);
        check("rd_rresp", {30'd0, rresp}, 32'd0);
        data = rdata;
        tick();
        check("rd_rvalid_clr", {31'd0, rvalid}, 32'd0);
    endtask

    // Aligns on the first row-0 cycle after row 7, then checks n cycles by
    // arithmetic: row = (k / (div+1)) mod 8.
    task automatic scan_expect(input int div, input logic [63:0] pixv, input bit inv, input int n);
        bit got = 0;
        int row;
        logic [7:0] ecol;
        for (int i = 0; i < 8 * (div + 1) + 20 && !got; i++) begin
            tick();
            if (row_sel == 8'h80) got = 1;
        end
        check("scan_reach_row7", {24'd0, row_sel}, 32'h80);
        got = 0;
        for (int i = 0; i < div + 4 && !got; i++) begin
            tick();
            if (row_sel != 8'h80) got = 1;
        end
        for (int k = 0; k < n; k++) begin
            row  = (k / (div + 1)) % 8;
            ecol = pixv[row*8 +: 8] ^ (inv ? 8'hFF : 8'h00);
            check("scan_row_sel", {24'd0, row_sel}, 32'(1 << row));
            check("scan_col_data", {24'd0, col_data}, {24'd0, ecol});
            tick();
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] held;
        logic [3:0]  a;
        logic [31:0] d;
        logic [63:0] pixv;
        int          dv;
        bit          inv;
        bit          got;

        vecs[0] = '{4'h0, 32'h0000_0001, 4'hF, 32'h0000_0001};
        vecs[1] = '{4'h4, 32'h0000_0002, 4'hF, 32'h0000_0002};
        vecs[2] = '{4'h8, 32'h0000_0003, 4'hF, 32'h0000_0003};
        vecs[3] = '{4'hC, 32'h0000_0004, 4'hF, 32'h0000_0004};
        vecs[4] = '{4'h0, 32'h0000_0001, 4'hF, 32'h0000_0001};
        vecs[5] = '{4'h0, 32'hAABB_CCDD, 4'h2, 32'h0000_CC01};
        vecs[6] = '{4'h4, 32'h1234_5678, 4'h8, 32'h1200_0002};
        vecs[7] = '{4'h8, 32'hDEAD_BEEF, 4'h5, 32'h00AD_00EF};
        vecs[8] = '{4'hC, 32'hFFFF_FFFF, 4'h0, 32'h0000_0004};
        vecs[9] = '{4'hC, 32'hFFFF_FF00, 4'hE, 32'hFFFF_FF04};

        for (int i = 0; i < 4; i++) regs_m[i] = '0;
        areset = 1; awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0;
        wvalid = 0; bready = 0; araddr = 0; arprot = 0; arvalid = 0; rready = 0;
        repeat (3) tick();
        areset = 0;
        tick();
        check("rst_awready", {31'd0, awready}, 32'd0);
        check("rst_bvalid", {31'd0, bvalid}, 32'd0);
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_row_sel", {24'd0, row_sel}, 32'd0);
        check("rst_col_data", {24'd0, col_data}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
            axi_read(vecs[i].addr, rd);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
        end

        // AW leads W by 3 cycles, response held back 5 cycles
        awaddr = 4'h8; wdata = 32'h0000_0007; wstrb = 4'hF; awvalid = 1; wvalid = 0; bready = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("lead_awready_low", {31'd0, awready}, 32'd0);
        end
        wvalid = 1;
        tick();
        check("lead_awready", {31'd0, awready}, 32'd1);
        check("lead_wready", {31'd0, wready}, 32'd1);
        tick();
        awvalid = 0; wvalid = 0;
        check("lead_awready_pulse", {31'd0, awready}, 32'd0);
        check("lead_wready_pulse", {31'd0, wready}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            check("lead_bvalid_hold", {31'd0, bvalid}, 32'd1);
            if (i < 4) tick();
        end
        bready = 1;
        tick();
        check("lead_bvalid_drop", {31'd0, bvalid}, 32'd0);
        regs_m[2] = 32'h0000_0007;
        axi_read(4'h8, rd);
        check("lead_readback", rd, 32'h0000_0007);

        // rdata stable while rready low
        araddr = 4'h4; arvalid = 1; rready = 0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (arready) got = 1;
        end
        check("stall_arready", {31'd0, arready}, 32'd1);
        tick();
        arvalid = 0;
        held = regs_m[1];
        for (int i = 0; i < 3; i++) begin
            check("stall_rvalid", {31'd0, rvalid}, 32'd1);
            check("stall_rdata", rdata, held);
            tick();
        end
        rready = 1;
        tick();
        check("stall_rvalid_drop", {31'd0, rvalid}, 32'd0);

        // Simultaneous read and write of the same register returns old data
        axi_write(4'h0, 32'h1111_1111, 4'hF);
        awaddr = 4'h0; wdata = 32'h2222_2222; wstrb = 4'hF; araddr = 4'h0;
        awvalid = 1; wvalid = 1; arvalid = 1; bready = 1; rready = 1;
        wait_awready("coll_awready");
        check("coll_arready", {31'd0, arready}, 32'd1);
        tick();
        awvalid = 0; wvalid = 0; arvalid = 0;
        check("coll_rvalid", {31'd0, rvalid}, 32'd1);
        check("coll_rdata_old", rdata, 32'h1111_1111);
        tick();
        regs_m[0] = 32'h2222_2222;
        axi_read(4'h0, rd);
        check("coll_readback_new", rd, 32'h2222_2222);

        // Scanner: DIV=1, each row held two cycles, wraps to row 0
        axi_write(4'hC, 32'h0, 4'hF);
        axi_write(4'h0, 32'h0403_0201, 4'hF);
        axi_write(4'h4, 32'h0807_0605, 4'hF);
        axi_write(4'h8, 32'h0000_0001, 4'hF);
        axi_write(4'hC, 32'h0000_0001, 4'hF);
        scan_expect(1, 64'h0807_0605_0403_0201, 1'b0, 17);

        // Inverted columns, then disable mid-scan, then re-enable
        axi_write(4'hC, 32'h0000_0003, 4'hF);
        scan_expect(1, 64'h0807_0605_0403_0201, 1'b1, 5);
        awaddr = 4'hC; wdata = 32'h0; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
        wait_awready("dis_awready");
        check("dis_still_on", {31'd0, row_sel != 8'h00}, 32'd1);
        tick();
        awvalid = 0; wvalid = 0;
        check("dis_row_sel", {24'd0, row_sel}, 32'd0);
        check("dis_col_data", {24'd0, col_data}, 32'd0);
        tick();
        regs_m[3] = 32'h0;
        axi_write(4'hC, 32'h0000_0001, 4'hF);
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (row_sel != 8'h00) got = 1;
            else tick();
        end
        check("reen_row_sel", {24'd0, row_sel}, 32'h01);
        check("reen_col_data", {24'd0, col_data}, 32'h01);

        // Randomized register traffic against the model
        for (int i = 0; i < 60; i++) begin
            a = 4'($urandom_range(0, 3)) << 2;
            if ($urandom_range(0, 1) == 1) begin
                axi_write(a, $urandom, 4'($urandom_range(0, 15)));
            end else begin
                axi_read(a, rd);
                check($sformatf("rand_rd%0d", i), rd, regs_m[a[3:2]]);
            end
        end

        // Randomized scanner configurations
        for (int t = 0; t < 3; t++) begin
            dv   = $urandom_range(0, 3);
            pixv = {$urandom, $urandom};
            inv  = 1'($urandom_range(0, 1));
            axi_write(4'hC, 32'h0, 4'hF);
            axi_write(4'h0, pixv[31:0], 4'hF);
            axi_write(4'h4, pixv[63:32], 4'hF);
            d = {16'($urandom), 16'(dv)};
            axi_write(4'h8, d, 4'hF);
            d = {30'($urandom), inv, 1'b1};
            axi_write(4'hC, d, 4'hF);
            scan_expect(dv, pixv, inv, 16 * (dv + 1) + 1);
        end

        // Reset while a write response is pending
        awaddr = 4'h0; wdata = 32'h5555_5555; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
        wait_awready("rstp_awready");
        tick();
        check("rstp_bvalid_before", {31'd0, bvalid}, 32'd1);
        areset = 1; awvalid = 0; wvalid = 0;
        tick();
        check("rstp_bvalid_after", {31'd0, bvalid}, 32'd0);
        check("rstp_row_sel", {24'd0, row_sel}, 32'd0);
        areset = 0; bready = 1;
        for (int i = 0; i < 4; i++) regs_m[i] = '0;
        tick();
        check("rstp_bvalid_idle", {31'd0, bvalid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), rd);
            check($sformatf("rstp_reg%0d", i), rd, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
